farm_sensor_ctrl: RTL and testbench

Farm-road vehicle detector front end; produces the `sensor` request consumed by the highway/farm traffic light controller.
- Conditions a raw, asynchronous, bouncy inductive-loop input and counts queued farm-road vehicles.
- Watches the controller's `light_farm` output so it can model vehicles departing on green.
- Drops the request once the queue drains, with a hold-off so the highway is not starved.

---
 rtl/farm_sensor_ctrl.sv | 128 ++++++++++++
 tb/tb_farm_sensor_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/farm_sensor_ctrl.sv
// Farm-road loop detector front end: synchronizes and debounces the loop,
// keeps a queued-vehicle count and raises the request for the light controller.
module farm_sensor_ctrl #(
   parameter int DEB_CYCLES  = 4,
   parameter int PASS_CYCLES = 8,
   parameter int HOLD_CYCLES = 16,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             loop_in,
   input  logic [2:0]       light_farm,
   output logic             sensor,
   output logic [CNT_W-1:0] queue_count,
   output logic             overflow
);

   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int PW = $clog2(PASS_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [PW-1:0] PASS_LAST = PW'(PASS_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_Q = '1;

   typedef enum logic [1:0] {
      IDLE,
      REQUEST,
      SERVING,
      HOLDOFF
   } state_e;

   state_e state_q, state_d;
   logic s1_q, s2_q;
   logic deb_q, deb_d;
   logic arr_q, arr_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [PW-1:0] pass_q, pass_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic ovf_q, ovf_d;
   logic sensor_q;
   logic green, busy, depart;

   always_comb begin
      deb_d  = deb_q;
      dcnt_d = '0;
      arr_d  = 1'b0;
      if (s2_q != deb_q) begin
         if (dcnt_q == DEB_LAST) begin
            deb_d = ~deb_q;
            arr_d = ~deb_q;
         end else begin
            dcnt_d = dcnt_q + 1'b1;
         end
      end
   end

   assign green  = (light_farm == 3'b001);
   assign busy   = green && (cnt_q != '0);
   assign depart = busy && (pass_q == PASS_LAST);

   always_comb begin
      pass_d = (busy && !depart) ? pass_q + 1'b1 : '0;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      if (arr_q && !depart) begin
         if (cnt_q == MAX_Q) ovf_d = 1'b1;
         else                cnt_d = cnt_q + 1'b1;
      end else if (depart && !arr_q) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = '0;
      unique case (state_q)
         IDLE:    if (cnt_d != '0) state_d = REQUEST;
         REQUEST: if (green) state_d = SERVING;
         SERVING: begin
            if (cnt_d == '0)  state_d = HOLDOFF;
            else if (!green) state_d = REQUEST;
         end
         HOLDOFF: begin
            // Hold the request off so the highway gets its turn.
            if (hold_q == HOLD_LAST)
               state_d = (cnt_d == '0) ? IDLE : REQUEST;
            else
               hold_d = hold_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         deb_q    <= 1'b0;
         dcnt_q   <= '0;
         arr_q    <= 1'b0;
         pass_q   <= '0;
         hold_q   <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         state_q  <= IDLE;
         sensor_q <= 1'b0;
      end else begin
         s1_q     <= loop_in;
         s2_q     <= s1_q;
         deb_q    <= deb_d;
         dcnt_q   <= dcnt_d;
         arr_q    <= arr_d;
         pass_q   <= pass_d;
         hold_q   <= hold_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         sensor_q <= (state_d == REQUEST) || (state_d == SERVING);
      end
   end

   assign sensor      = sensor_q;
   assign queue_count = cnt_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_farm_sensor_ctrl.sv
// Randomized and directed bench for farm_sensor_ctrl against a
// cycle-timestamp reference model.
module tb_farm_sensor_ctrl;

   localparam int DEB  = 4;
   localparam int PASS = 8;
   localparam int HOLD = 16;
   localparam int CW   = 4;
   localparam int MAXQ = (1 << CW) - 1;

   localparam int P_IDLE = 0;
   localparam int P_REQ  = 1;
   localparam int P_SERV = 2;
   localparam int P_HOLD = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          lp = 1'b0;
   logic [2:0]    lf = 3'b100;
   logic          sensor;
   logic [CW-1:0] queue_count;
   logic          overflow;

   int n_chk = 0;
   int n_fail = 0;

   int cyc, sh1, sh2, m_lvl, m_run, m_arr, m_busy_run;
   int m_q, m_ovf, m_ph, m_hold_start, m_sensor;

   farm_sensor_ctrl #(
      .DEB_CYCLES (DEB),
      .PASS_CYCLES(PASS),
      .HOLD_CYCLES(HOLD),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .loop_in    (lp),
      .light_farm (lf),
      .sensor     (sensor),
      .queue_count(queue_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      sh1 = 0; sh2 = 0; m_lvl = 0; m_run = 0; m_arr = 0;
      m_busy_run = 0; m_q = 0; m_ovf = 0; m_ph = P_IDLE;
      m_hold_start = 0; m_sensor = 0;
   endtask

   task automatic m_step();
      bit green, arr, busy, dep;
      cyc++;
      green = (lf == 3'b001);
      arr   = (m_arr != 0);
      busy  = green && (m_q > 0);
      dep   = busy && ((m_busy_run + 1) % PASS == 0);
      m_busy_run = busy ? m_busy_run + 1 : 0;
      if (arr && !dep) begin
         if (m_q == MAXQ) m_ovf = 1;
         else             m_q++;
      end else if (dep && !arr) begin
         m_q--;
      end
      case (m_ph)
         P_IDLE: if (m_q > 0) m_ph = P_REQ;
         P_REQ:  if (green) m_ph = P_SERV;
         P_SERV: begin
            if (m_q == 0) begin
               m_ph = P_HOLD;
               m_hold_start = cyc;
            end else if (!green) begin
               m_ph = P_REQ;
            end
         end
         default: begin
            if (cyc - m_hold_start == HOLD)
               m_ph = (m_q == 0) ? P_IDLE : P_REQ;
         end
      endcase
      m_arr = 0;
      if (sh2 != m_lvl) begin
         m_run++;
         if (m_run == DEB) begin
            m_lvl = sh2;
            m_run = 0;
            m_arr = m_lvl;
         end
      end else begin
         m_run = 0;
      end
      sh2 = sh1;
      sh1 = int'(lp);
      m_sensor = (m_ph == P_REQ || m_ph == P_SERV) ? 1 : 0;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst_n) m_reset();
      else        m_step();
      #1;
      check("queue", int'(queue_count), m_q);
      check("sensor", int'(sensor), m_sensor);
      check("ovf", int'(overflow), m_ovf);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      m_reset();
      for (int i = 0; i < 10; i++) begin
         lp = ~lp;
         cycle();
         check("rst_q", int'(queue_count), 0);
         check("rst_s", int'(sensor), 0);
      end
      rst_n = 1'b1;
      lp = 1'b0;
      lf = 3'b100;
      repeat (8) cycle();
   endtask

   task automatic arrive();
      lp = 1'b1;
      repeat (8) cycle();
      lp = 1'b0;
      repeat (8) cycle();
   endtask

   initial begin
      cyc = 0;
      m_reset();
      #2;
      do_reset();
      check("idle_q", int'(queue_count), 0);
      check("idle_ovf", int'(overflow), 0);

      lp = 1'b1;
      repeat (6) cycle();
      check("arr_e6", int'(queue_count), 0);
      cycle();
      check("arr_e7", int'(queue_count), 1);
      check("arr_sens", int'(sensor), 1);
      repeat (13) cycle();
      lp = 1'b0;
      repeat (12) cycle();
      check("no_2nd", int'(queue_count), 1);

      do_reset();
      for (int k = 0; k < 5; k++) begin
         lp = 1'b1;
         repeat (3) cycle();
         lp = 1'b0;
         repeat (2) cycle();
      end
      repeat (8) cycle();
      check("bounce_q", int'(queue_count), 0);
      check("bounce_s", int'(sensor), 0);

      do_reset();
      repeat (3) arrive();
      check("svc_q3", int'(queue_count), 3);
      lf = 3'b001;
      repeat (8) cycle();
      check("svc_q2", int'(queue_count), 2);
      repeat (16) cycle();
      check("svc_q0", int'(queue_count), 0);
      check("svc_s0", int'(sensor), 0);
      repeat (6) cycle();
      lf = 3'b100;
      repeat (20) cycle();

      do_reset();
      repeat (5) arrive();
      lf = 3'b001;
      repeat (10) cycle();
      lf = 3'b010;
      cycle();
      check("intr_q", int'(queue_count), 4);
      check("intr_s", int'(sensor), 1);
      lf = 3'b001;
      repeat (7) cycle();
      check("resume_q4", int'(queue_count), 4);
      cycle();
      check("resume_q3", int'(queue_count), 3);

      do_reset();
      repeat (16) arrive();
      check("sat_q", int'(queue_count), MAXQ);
      check("sat_ovf", int'(overflow), 1);
      lf = 3'b001;
      repeat (20) cycle();
      check("ovf_sticky", int'(overflow), 1);

      do_reset();
      for (int i = 0; i < 300; i++) begin
         int hl, hg;
         hl = $urandom_range(1, 12);
         lp = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 3) == 0) begin
            hg = $urandom_range(0, 5);
            lf = (hg < 3) ? 3'b001 : (hg == 3) ? 3'b010 :
                 (hg == 4) ? 3'b100 : 3'($urandom_range(0, 7));
         end
         if (i == 150) begin
            #3;
            rst_n = 1'b0;
            #1;
            m_reset();
            check("async_q", int'(queue_count), 0);
            check("async_s", int'(sensor), 0);
            check("async_ovf", int'(overflow), 0);
            cycle();
            cycle();
            rst_n = 1'b1;
         end
         repeat (hl) cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
